// File: rtl/text_banner_ctrl_if.sv
// Frame-sequencer control/status bundle between the banner sequencer and the overlay path.
// master drives requests and frame ticks; slave is the sequencer producing banner position and enables.
interface text_banner_ctrl_if;
    logic       refr_tick;
    logic       start;
    logic       reset_req;
    logic [9:0] text_x;
    logic [9:0] text_y;
    logic       title_en;
    logic       resetting_en;
    logic       board_clear;
    logic       busy;
    logic       reset_done;

    modport master (
        output refr_tick, start, reset_req,
        input  text_x, text_y, title_en, resetting_en, board_clear, busy, reset_done
    );

    modport slave (
        input  refr_tick, start, reset_req,
        output text_x, text_y, title_en, resetting_en, board_clear, busy, reset_done
    );
endinterface

// File: rtl/text_banner_ctrl.sv
// Frame-rate sequencer for the title slide-in and the blinking RESETTING notice.
// All outputs registered (1-cycle latency); no backpressure, paced only by refr_tick.
module text_banner_ctrl #(
    parameter int TITLE_X      = 192,
    parameter int TITLE_Y      = 32,
    parameter int SLIDE_STEP   = 2,
    parameter int RESET_X      = 192,
    parameter int RESET_Y      = 232,
    parameter int BLINK_FRAMES = 16,
    parameter int RESET_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset_n,
    text_banner_ctrl_if.slave bus
);
    localparam int FW = (RESET_FRAMES > 1) ? $clog2(RESET_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(RESET_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [9:0]    TITLE_X_C  = 10'(TITLE_X);
    localparam logic [9:0]    TITLE_Y_C  = 10'(TITLE_Y);
    localparam logic [9:0]    RESET_X_C  = 10'(RESET_X);
    localparam logic [9:0]    RESET_Y_C  = 10'(RESET_Y);

    typedef enum logic [1:0] {
        ST_SLIDE,
        ST_TITLE,
        ST_PLAY,
        ST_RESETTING
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    text_x_q, text_x_d;
    logic [9:0]    text_y_q, text_y_d;
    logic          title_en_q, title_en_d;
    logic          resetting_en_q, resetting_en_d;
    logic          board_clear_q, board_clear_d;
    logic          busy_q, busy_d;
    logic          reset_done_q, reset_done_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [10:0]   slide_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_SLIDE;
            text_x_q       <= TITLE_X_C;
            text_y_q       <= '0;
            title_en_q     <= 1'b1;
            resetting_en_q <= 1'b0;
            board_clear_q  <= 1'b0;
            busy_q         <= 1'b0;
            reset_done_q   <= 1'b0;
            frame_cnt_q    <= '0;
            blink_cnt_q    <= '0;
            blink_ph_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            text_x_q       <= text_x_d;
            text_y_q       <= text_y_d;
            title_en_q     <= title_en_d;
            resetting_en_q <= resetting_en_d;
            board_clear_q  <= board_clear_d;
            busy_q         <= busy_d;
            reset_done_q   <= reset_done_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_ph_q     <= blink_ph_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        text_x_d       = text_x_q;
        text_y_d       = text_y_q;
        title_en_d     = title_en_q;
        resetting_en_d = resetting_en_q;
        board_clear_d  = 1'b0;
        busy_d         = busy_q;
        reset_done_d   = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        blink_cnt_d    = blink_cnt_q;
        blink_ph_d     = blink_ph_q;
        // Widened so a large step near the top of the range cannot wrap past TITLE_Y.
        slide_sum      = {1'b0, text_y_q} + 11'(SLIDE_STEP);

        if (state_q != ST_RESETTING && bus.reset_req) begin
            state_d        = ST_RESETTING;
            text_x_d       = RESET_X_C;
            text_y_d       = RESET_Y_C;
            title_en_d     = 1'b0;
            resetting_en_d = 1'b1;
            board_clear_d  = 1'b1;
            busy_d         = 1'b1;
            frame_cnt_d    = '0;
            blink_cnt_d    = '0;
            blink_ph_d     = 1'b1;
        end else begin
            case (state_q)
                ST_SLIDE: begin
                    if (bus.refr_tick) begin
                        if (slide_sum >= 11'(TITLE_Y)) begin
                            text_y_d = TITLE_Y_C;
                            state_d  = ST_TITLE;
                        end else begin
                            text_y_d = slide_sum[9:0];
                        end
                    end
                end
                ST_TITLE: begin
                    if (bus.start) begin
                        state_d    = ST_PLAY;
                        title_en_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    state_d = ST_PLAY;
                end
                ST_RESETTING: begin
                    if (bus.refr_tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            state_d        = ST_SLIDE;
                            text_x_d       = TITLE_X_C;
                            text_y_d       = '0;
                            title_en_d     = 1'b1;
                            resetting_en_d = 1'b0;
                            busy_d         = 1'b0;
                            reset_done_d   = 1'b1;
                            frame_cnt_d    = '0;
                            blink_cnt_d    = '0;
                            blink_ph_d     = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_d    = '0;
                                blink_ph_d     = ~blink_ph_q;
                                resetting_en_d = ~blink_ph_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_SLIDE;
                end
            endcase
        end
    end

    assign bus.text_x       = text_x_q;
    assign bus.text_y       = text_y_q;
    assign bus.title_en     = title_en_q;
    assign bus.resetting_en = resetting_en_q;
    assign bus.board_clear  = board_clear_q;
    assign bus.busy         = busy_q;
    assign bus.reset_done   = reset_done_q;
endmodule

// File: doc/text_banner_ctrl.md
# text_banner_ctrl

Frame-rate sequencer for the two 256x16 text banners ("BEJEWELED" title and "RESETTING" notice) in the VGA overlay path. It drives each banner module's shared top-left position input and the per-banner enables that gate their `on` outputs in the pixel mux. It slides the title in at power-up, holds it until the player starts, and runs a timed, blinking "RESETTING" notice with a board-clear handshake when the game is reset.

## Interface
Parameters:
- TITLE_X, 192: title top-left x. (640-256)/2, centered.
- TITLE_Y, 32: final title top-left y after the slide.
- SLIDE_STEP, 2: pixels the title moves down per frame.
- RESET_X, 192: RESETTING top-left x.
- RESET_Y, 232: RESETTING top-left y. Vertically centered.
- BLINK_FRAMES, 16: frames per blink half-period. Must be ≥1.
- RESET_FRAMES, 120: total frames the RESETTING notice is shown. Must be ≥1.

Ports:
- clk, input, 1: pixel/system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- refr_tick, input, 1: one-cycle pulse per frame, at start of vertical blank.
- start, input, 1: player start request. Level, sampled every clk.
- reset_req, input, 1: game reset request. Level, sampled every clk.
- text_x, output, 10: top-left x fed to both banner modules.
- text_y, output, 10: top-left y fed to both banner modules.
- title_en, output, 1: gates the BEJEWELED banner `on`.
- resetting_en, output, 1: gates the RESETTING banner `on`.
- board_clear, output, 1: one-cycle pulse commanding the board logic to reinitialize.
- busy, output, 1: high while in RESETTING.
- reset_done, output, 1: one-cycle pulse when RESETTING completes.

## Operation
- All outputs are registered. Reset values: state SLIDE, text_x=TITLE_X, text_y=0, title_en=1, resetting_en=0, board_clear=0, busy=0, reset_done=0. Internal frame counter and blink counter are 0 and blink phase is 1 (visible).
- FSM states: SLIDE, TITLE, PLAY, RESETTING. Priority in every state except RESETTING: reset_req over start over refr_tick.
- SLIDE:
  - On refr_tick, if text_y + SLIDE_STEP ≥ TITLE_Y (11-bit compare, no wrap), set text_y=TITLE_Y and go to TITLE. Otherwise text_y += SLIDE_STEP.
  - start is ignored.
- TITLE:
  - Title is static at (TITLE_X, TITLE_Y).
  - start=1 → PLAY; title_en=0.
- PLAY:
  - Both enables are 0. text_x and text_y hold their last values.
- Entry to RESETTING from SLIDE, TITLE or PLAY on reset_req=1:
  - text_x=RESET_X, text_y=RESET_Y, title_en=0, resetting_en=1, busy=1.
  - board_clear pulses for exactly that one cycle.
  - Frame counter, blink counter and blink phase are cleared to 0, 0, 1.
- RESETTING:
  - On each refr_tick the frame counter increments and the blink counter increments.
  - When the blink counter reaches BLINK_FRAMES-1 on a tick, it returns to 0 and the blink phase toggles.
  - resetting_en = blink phase.
  - reset_req and start are ignored; the sequence is never restarted.
  - On the tick where the frame counter reaches RESET_FRAMES-1, go to SLIDE: text_x=TITLE_X, text_y=0, title_en=1, resetting_en=0, busy=0, and reset_done pulses for one cycle.
- Counter widths are sized by $clog2 of the parameter. Counters never wrap inside a state.

## Timing
- Every transition takes effect on the clk edge where its condition is sampled. Outputs change in the following cycle (1-cycle latency).
- A refr_tick in the same cycle as RESETTING entry is not counted.
- A refr_tick in the same cycle as start in TITLE is irrelevant.
- reset_req held high continuously re-enters RESETTING on the cycle after reset_done, because it is sampled in SLIDE. board_clear and reset_done are therefore never high in the same cycle.
- RESETTING lasts exactly RESET_FRAMES refr_ticks after entry.
- The slide takes ceil(TITLE_Y/SLIDE_STEP) ticks.
- Assertion of reset_n mid-sequence returns immediately (asynchronously) to reset values; no board_clear or reset_done is emitted.

## Test plan
- Reset, then 16 refr_ticks with default parameters: text_y steps 0, 2, …, 30, 32. State is TITLE after the 16th tick, title_en=1, resetting_en=0.
- In TITLE, pulse start: next cycle title_en=0, resetting_en=0. A further 5 ticks cause no output change.
- In PLAY, assert reset_req: next cycle board_clear=1 for one cycle, busy=1, text=(192,232), resetting_en=1. resetting_en toggles after ticks 16, 32, 48, and so on.
- Continue to 120 ticks: reset_done pulses one cycle after the 120th tick, busy=0, text=(192,0), title_en=1, and the slide replays.
- start and reset_req high together in TITLE: RESETTING is entered, not PLAY. reset_req re-pulsed mid-RESETTING: completion still occurs at tick 120.
- Assert reset_n low at tick 60 of RESETTING: outputs are immediately at reset values and no reset_done pulse appears.
